video_packetizer: RTL and testbench

VIDEO_PACKETIZER -- requirements
Module: video_packetizer

---
 rtl/video_packetizer.sv | 153 +++++++++++++++
 tb/tb_video_packetizer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/video_packetizer.sv
// Wraps an elementary byte stream into start-code packets: 00 00 01 id, 16-bit length,
// optional 5-byte PTS header (else 0F), then up to PAYLOAD_MAX payload bytes.
//   state   | meaning
//   IDLE    | wait for a full payload, or a final partial one once es_end is set
//   START   | emit 00 00 01 STREAM_ID
//   LEN_HI  | emit length[15:8]
//   LEN_LO  | emit length[7:0]
//   HDR     | emit 0F, or five PTS bytes when a timestamp was latched
//   PAYLOAD | forward plen source bytes, bubbling while the source is empty
//   DONE    | stream finished, stream_end_out held until reset
module video_packetizer #(
  parameter int          PAYLOAD_MAX = 2048,
  parameter logic [7:0]  STREAM_ID   = 8'hE0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic [7:0]  es_in,
  input  logic        es_empty,
  input  logic [15:0] es_level,
  input  logic        es_end,
  output logic        es_rd,
  input  logic        pts_valid,
  input  logic [32:0] pts,
  output logic        pts_ack,
  input  logic        out_afull,
  output logic [7:0]  stream_out,
  output logic        stream_wr,
  output logic        stream_end_out
);

  typedef enum logic [2:0] {IDLE, START, LEN_HI, LEN_LO, HDR, PAYLOAD, DONE} state_t;

  localparam logic [15:0] PMAX = 16'(PAYLOAD_MAX);

  state_t      state;
  logic [15:0] remaining;
  logic [15:0] len_field;
  logic [2:0]  idx;
  logic        has_pts;
  logic [32:0] pts_q;

  logic        emit;
  logic        start_pkt;
  logic [15:0] plen_next;
  logic [7:0]  start_byte;
  logic [7:0]  hdr_byte;

  assign emit      = clk_en && !out_afull;
  assign start_pkt = (es_level >= PMAX) || (es_end && es_level != 16'd0);
  assign plen_next = (es_level >= PMAX) ? PMAX : es_level;
  assign es_rd     = rst && emit && !es_empty && (state == PAYLOAD);

  always_comb begin
    start_byte = STREAM_ID;
    case (idx)
      3'd0:    start_byte = 8'h00;
      3'd1:    start_byte = 8'h00;
      3'd2:    start_byte = 8'h01;
      default: start_byte = STREAM_ID;
    endcase
  end

  // PTS marker-bit layout: each 15-bit chunk is followed by a 1 marker bit.
  always_comb begin
    hdr_byte = 8'h0F;
    if (has_pts) begin
      case (idx)
        3'd0:    hdr_byte = {4'b0010, pts_q[32:30], 1'b1};
        3'd1:    hdr_byte = pts_q[29:22];
        3'd2:    hdr_byte = {pts_q[21:15], 1'b1};
        3'd3:    hdr_byte = pts_q[14:7];
        default: hdr_byte = {pts_q[6:0], 1'b1};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      remaining      <= 16'd0;
      len_field      <= 16'd0;
      idx            <= 3'd0;
      has_pts        <= 1'b0;
      pts_q          <= 33'd0;
      pts_ack        <= 1'b0;
      stream_out     <= 8'h00;
      stream_wr      <= 1'b0;
      stream_end_out <= 1'b0;
    end else if (clk_en) begin
      stream_wr <= 1'b0;
      pts_ack   <= 1'b0;
      case (state)
        IDLE: begin
          if (start_pkt) begin
            state     <= START;
            remaining <= plen_next;
            len_field <= 16'(plen_next + (pts_valid ? 16'd5 : 16'd1));
            has_pts   <= pts_valid;
            pts_q     <= pts;
            pts_ack   <= pts_valid;
            idx       <= 3'd0;
          end else if (es_end && es_level == 16'd0 && es_empty) begin
            state          <= DONE;
            stream_end_out <= 1'b1;
          end
        end
        START: if (emit) begin
          stream_wr  <= 1'b1;
          stream_out <= start_byte;
          if (idx == 3'd3) begin
            idx   <= 3'd0;
            state <= LEN_HI;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        LEN_HI: if (emit) begin
          stream_wr  <= 1'b1;
          stream_out <= len_field[15:8];
          state      <= LEN_LO;
        end
        LEN_LO: if (emit) begin
          stream_wr  <= 1'b1;
          stream_out <= len_field[7:0];
          state      <= HDR;
        end
        HDR: if (emit) begin
          stream_wr  <= 1'b1;
          stream_out <= hdr_byte;
          if (!has_pts || idx == 3'd4) begin
            idx   <= 3'd0;
            state <= PAYLOAD;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        PAYLOAD: if (emit && !es_empty) begin
          stream_wr  <= 1'b1;
          stream_out <= es_in;
          remaining  <= remaining - 16'd1;
          if (remaining == 16'd1) state <= IDLE;
        end
        DONE: stream_end_out <= 1'b1;
        default: state <= IDLE;
      endcase
    end else begin
      stream_wr <= 1'b0;
      pts_ack   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_packetizer.sv
// Scoreboard bench for video_packetizer: directed packets with hand-computed byte streams,
// a model source FIFO, and a negedge monitor that pops expected bytes on each stream_wr.
module tb_video_packetizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic [7:0]  es_in;
  logic        es_empty;
  logic [15:0] es_level;
  logic        es_end;
  logic        es_rd;
  logic        pts_valid;
  logic [32:0] pts;
  logic        pts_ack;
  logic        out_afull;
  logic [7:0]  stream_out;
  logic        stream_wr;
  logic        stream_end_out;

  logic [7:0] fifo[$];
  logic [7:0] exp_q[$];
  logic       gate;
  int         checks = 0;
  int         failures = 0;
  int         wr_count = 0;
  int         pts_ack_cnt = 0;

  video_packetizer #(.PAYLOAD_MAX(4), .STREAM_ID(8'hE0)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .es_in(es_in), .es_empty(es_empty), .es_level(es_level), .es_end(es_end), .es_rd(es_rd),
    .pts_valid(pts_valid), .pts(pts), .pts_ack(pts_ack),
    .out_afull(out_afull),
    .stream_out(stream_out), .stream_wr(stream_wr), .stream_end_out(stream_end_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic void refresh();
    es_in    = (fifo.size() != 0) ? fifo[0] : 8'h00;
    es_empty = (fifo.size() == 0) || gate;
    es_level = 16'(fifo.size());
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Source FIFO pops after the edge so the DUT samples the pre-pop head.
  always @(posedge clk) begin
    if (es_rd) begin
      #1;
      if (fifo.size() != 0) fifo.delete(0);
      refresh();
    end
  end

  always @(negedge clk) begin
    if (stream_wr) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_wr actual=0x%0h required=no_write", stream_out);
      end else begin
        chk("stream_byte", {56'd0, stream_out}, {56'd0, exp_q.pop_front()});
      end
    end
    if (pts_ack) begin
      pts_ack_cnt++;
      pts_valid = 1'b0;
    end
    if (es_rd) chk("rd_while_empty", {63'd0, es_empty}, 64'd0);
  end

  task automatic drain(input string name, input int budget, input bit toggle);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      if (toggle) begin
        gate = !gate;
        refresh();
      end
      tick();
      n++;
    end
    gate = 1'b0;
    refresh();
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_stream_wr", {63'd0, stream_wr}, 64'd0);
    chk("rst_stream_out", {56'd0, stream_out}, 64'd0);
    chk("rst_pts_ack", {63'd0, pts_ack}, 64'd0);
    chk("rst_stream_end", {63'd0, stream_end_out}, 64'd0);
    chk("rst_es_rd", {63'd0, es_rd}, 64'd0);
  endtask

  initial begin
    rst = 1'b0; clk_en = 1'b1; es_end = 1'b0; pts_valid = 1'b0; pts = 33'd0;
    out_afull = 1'b0; gate = 1'b0;
    refresh();
    tick(); tick();
    check_reset_outputs();
    rst = 1'b1;
    tick();

    // Plain packet, no PTS: length 4+1 = 5.
    exp_q = {8'h00, 8'h00, 8'h01, 8'hE0, 8'h00, 8'h05, 8'h0F, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    fifo = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
    refresh();
    wr_count = 0;
    drain("pkt_plain", 60, 1'b0);
    tick();
    chk("pkt_plain_writes", 64'(wr_count), 64'd11);

    // PTS 0x1_2345_6789: [32:30]=100 -> 29, [29:22]=8D, [21:15]=0A -> 15, [14:7]=CF, [6:0]=09 -> 13.
    pts_valid = 1'b1; pts = 33'h1_2345_6789;
    exp_q = {8'h00, 8'h00, 8'h01, 8'hE0, 8'h00, 8'h09, 8'h29, 8'h8D, 8'h15, 8'hCF, 8'h13,
             8'hAA, 8'hBB, 8'hCC, 8'hDD};
    fifo = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
    refresh();
    drain("pkt_pts", 60, 1'b0);
    tick();
    chk("pts_ack_count", 64'(pts_ack_cnt), 64'd1);

    // Stall for 5 cycles just before LEN_LO.
    exp_q = {8'h00, 8'h00, 8'h01, 8'hE0, 8'h00, 8'h05, 8'h0F, 8'h11, 8'h22, 8'h33, 8'h44};
    fifo = {8'h11, 8'h22, 8'h33, 8'h44};
    refresh();
    wr_count = 0;
    for (int n = 0; n < 50 && wr_count < 5; n++) tick();
    chk("stall_reached_len_hi", 64'(wr_count), 64'd5);
    out_afull = 1'b1;
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("stall_no_wr", {63'd0, stream_wr}, 64'd0);
    end
    out_afull = 1'b0;
    drain("pkt_stall", 60, 1'b0);

    // Source empty toggling every cycle: bubbles only, order preserved.
    exp_q = {8'h00, 8'h00, 8'h01, 8'hE0, 8'h00, 8'h05, 8'h0F, 8'h5A, 8'h6B, 8'h7C, 8'h8D};
    fifo = {8'h5A, 8'h6B, 8'h7C, 8'h8D};
    refresh();
    drain("pkt_bubble", 80, 1'b1);

    // Reset right after the 8th byte (first payload byte) of a packet.
    exp_q = {8'h00, 8'h00, 8'h01, 8'hE0, 8'h00, 8'h05, 8'h0F, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    fifo = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
    refresh();
    wr_count = 0;
    for (int n = 0; n < 50 && wr_count < 8; n++) tick();
    chk("reached_8th_byte", 64'(wr_count), 64'd8);
    rst = 1'b0;
    exp_q.delete();
    tick();
    check_reset_outputs();
    chk("fifo_after_rst", 64'(fifo.size()), 64'd3);
    fifo.delete();
    refresh();
    tick();
    rst = 1'b1;
    exp_q = {8'h00, 8'h00, 8'h01, 8'hE0, 8'h00, 8'h05, 8'h0F, 8'h01, 8'h02, 8'h03, 8'h04};
    fifo = {8'h01, 8'h02, 8'h03, 8'h04};
    refresh();
    drain("pkt_after_rst", 60, 1'b0);

    // Six bytes: one full packet of 4, the remaining 2 wait for es_end.
    exp_q = {8'h00, 8'h00, 8'h01, 8'hE0, 8'h00, 8'h05, 8'h0F, 8'h61, 8'h62, 8'h63, 8'h64};
    fifo = {8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66};
    refresh();
    drain("pkt_clamped", 60, 1'b0);
    for (int n = 0; n < 6; n++) tick();
    chk("partial_held", 64'(fifo.size()), 64'd2);
    exp_q = {8'h00, 8'h00, 8'h01, 8'hE0, 8'h00, 8'h03, 8'h0F, 8'h65, 8'h66};
    es_end = 1'b1;
    drain("pkt_tail", 60, 1'b0);
    tick(); tick();
    chk("stream_end_set", {63'd0, stream_end_out}, 64'd1);
    fifo = {8'h71, 8'h72, 8'h73, 8'h74};
    refresh();
    for (int n = 0; n < 10; n++) tick();
    chk("done_no_pop", 64'(fifo.size()), 64'd4);
    chk("stream_end_sticky", {63'd0, stream_end_out}, 64'd1);

    // Fresh stream: 3 bytes with es_end already high -> length 00 04, then DONE.
    rst = 1'b0; es_end = 1'b0;
    fifo.delete();
    refresh();
    tick(); tick();
    check_reset_outputs();
    rst = 1'b1;
    tick();
    exp_q = {8'h00, 8'h00, 8'h01, 8'hE0, 8'h00, 8'h04, 8'h0F, 8'hE1, 8'hE2, 8'hE3};
    fifo = {8'hE1, 8'hE2, 8'hE3};
    es_end = 1'b1;
    refresh();
    drain("pkt_short_end", 60, 1'b0);
    tick(); tick();
    chk("short_end_done", {63'd0, stream_end_out}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
